data_bus_arbiter: RTL and testbench

- Two-master arbiter that shares the single data-bus port of avalon_bus (memory and I/O) between the processor (M0) and a second requester (M1, e.g. DMA/debug loader).
- Sits between the requesters and avalon_bus; each master sees an unmodified request/done interface.
- Round-robin grant; one transaction per grant; a watchdog aborts transactions that never complete.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/data_bus_arbiter_rr_pick2.sv | 21 ++
 rtl/data_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWN_M0 = 1'b0;
  localparam owner_t OWN_M1 = 1'b1;

  localparam logic [15:0] ABORT_DATA_DFLT = 16'hDEAD;

endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master not served last wins.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_i,
  output owner_t     grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = OWN_M0;
    if (req_i == 2'b11) begin
      grant_o = owner_t'(~last_i);
    end else if (req_i[1]) begin
      grant_o = OWN_M1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one avalon_bus data port between two request/done masters with
// round-robin grant, one transaction per grant and a watchdog abort.
module data_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 16,
  parameter int                TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_W-1:0] ABORT_DATA     = DATA_W'(ABORT_DATA_DFLT)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              M0Read,
  input  logic              M0Write,
  input  logic [ADDR_W-1:0] M0Addr,
  input  logic [DATA_W-1:0] M0WrData,
  output logic [DATA_W-1:0] M0RdData,
  output logic              M0Done,
  input  logic              M1Read,
  input  logic              M1Write,
  input  logic [ADDR_W-1:0] M1Addr,
  input  logic [DATA_W-1:0] M1WrData,
  output logic [DATA_W-1:0] M1RdData,
  output logic              M1Done,
  output logic              BusRead,
  output logic              BusWrite,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusWrData,
  input  logic [DATA_W-1:0] BusRdData,
  input  logic              BusDone,
  output logic              Owner,
  output logic              TimeoutErr
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              terr_q, terr_d;

  logic [1:0]        req;
  owner_t            pick_grant;
  logic              pick_valid;
  logic              finish;
  logic [DATA_W-1:0] rd_val;

  assign req = {M1Read | M1Write, M0Read | M0Write};

  rr_pick2 u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  // The transaction ends on BusDone or on the last watchdog cycle; BusDone wins a tie.
  assign finish = (state_q == BUSY) && (BusDone || (wd_q == WD_LAST));
  assign rd_val = BusDone ? BusRdData : ABORT_DATA;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wd_d        = wd_q;
    terr_d      = terr_q;
    case (state_q)
      IDLE: begin
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_grant;
          wd_d    = '0;
          if (pick_grant == OWN_M1) begin
            bus_addr_d  = M1Addr;
            bus_wdata_d = M1WrData;
            bus_write_d = M1Write;
            bus_read_d  = M1Read & ~M1Write;
          end else begin
            bus_addr_d  = M0Addr;
            bus_wdata_d = M0WrData;
            bus_write_d = M0Write;
            bus_read_d  = M0Read & ~M0Write;
          end
        end
      end
      BUSY: begin
        if (finish) begin
          state_d     = RELEASE;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          last_d      = owner_q;
          if (!BusDone) begin
            terr_d = 1'b1;
          end
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_M0;
      last_q      <= OWN_M1;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      wd_q        <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wd_q        <= wd_d;
      terr_q      <= terr_d;
    end
  end

  assign M0Done     = finish && (owner_q == OWN_M0);
  assign M1Done     = finish && (owner_q == OWN_M1);
  assign M0RdData   = M0Done ? rd_val : '0;
  assign M1RdData   = M1Done ? rd_val : '0;
  assign BusRead    = bus_read_q;
  assign BusWrite   = bus_write_q;
  assign BusAddr    = bus_addr_q;
  assign BusWrData  = bus_wdata_q;
  assign Owner      = owner_q;
  assign TimeoutErr = terr_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed vector bench for data_bus_arbiter: per-cycle stimulus/expectation table
// plus hand-built reset-mid-transaction and done/timeout tie sequences.
module tb_data_bus_arbiter;

  localparam logic [15:0] A0 = 16'h0010;
  localparam logic [15:0] A1 = 16'h0FF0;
  localparam logic [15:0] D0 = 16'h00AA;
  localparam logic [15:0] D1 = 16'h5555;
  localparam logic [15:0] Z  = 16'h0000;

  logic        Clock, Reset;
  logic        M0Read, M0Write, M1Read, M1Write;
  logic [15:0] M0Addr, M0WrData, M1Addr, M1WrData;
  logic [15:0] M0RdData, M1RdData;
  logic        M0Done, M1Done;
  logic        BusRead, BusWrite, BusDone;
  logic [15:0] BusAddr, BusWrData, BusRdData;
  logic        Owner, TimeoutErr;

  int n_vec = 0;
  int n_bad = 0;

  data_bus_arbiter #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8), .ABORT_DATA(16'hDEAD)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .M0Read(M0Read), .M0Write(M0Write), .M0Addr(M0Addr), .M0WrData(M0WrData),
    .M0RdData(M0RdData), .M0Done(M0Done),
    .M1Read(M1Read), .M1Write(M1Write), .M1Addr(M1Addr), .M1WrData(M1WrData),
    .M1RdData(M1RdData), .M1Done(M1Done),
    .BusRead(BusRead), .BusWrite(BusWrite), .BusAddr(BusAddr), .BusWrData(BusWrData),
    .BusRdData(BusRdData), .BusDone(BusDone),
    .Owner(Owner), .TimeoutErr(TimeoutErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // req = {M0Read, M0Write, M1Read, M1Write}
  // exp = {BusRead, BusWrite, BusAddr, BusWrData, Owner, M0Done, M1Done, M0RdData, M1RdData, TimeoutErr}
  typedef struct {
    string       name;
    logic [3:0]  req;
    logic        bd;
    logic [15:0] brd;
    logic [69:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string nm, logic [3:0] req, logic bd, logic [15:0] brd,
                             logic [1:0] cmd, logic [15:0] ba, logic [15:0] bwd,
                             logic own, logic [1:0] done, logic [15:0] m0rd,
                             logic [15:0] m1rd, logic terr);
    vec_t t;
    t.name = nm;
    t.req  = req;
    t.bd   = bd;
    t.brd  = brd;
    t.exp  = {cmd, ba, bwd, own, done, m0rd, m1rd, terr};
    return t;
  endfunction

  task automatic drive(input vec_t t);
    @(negedge Clock);
    {M0Read, M0Write, M1Read, M1Write} = t.req;
    BusDone   = t.bd;
    BusRdData = t.brd;
  endtask

  task automatic compare(input vec_t t);
    logic [69:0] act;
    act = {BusRead, BusWrite, BusAddr, BusWrData, Owner, M0Done, M1Done,
           M0RdData, M1RdData, TimeoutErr};
    n_vec++;
    if (act !== t.exp) begin
      n_bad++;
      $display("FAIL %s: got rd/wr=%b%b addr=%h wd=%h own=%b done=%b%b rd0=%h rd1=%h terr=%b, required rd/wr=%b addr=%h wd=%h own=%b done=%b rd0=%h rd1=%h terr=%b",
               t.name, act[69], act[68], act[67:52], act[51:36], act[35], act[34], act[33],
               act[32:17], act[16:1], act[0],
               t.exp[69:68], t.exp[67:52], t.exp[51:36], t.exp[35], t.exp[34:33],
               t.exp[32:17], t.exp[16:1], t.exp[0]);
    end else if (t.exp[34] || t.exp[33]) begin
      $display("txn %s: owner=M%0d rddata=%h", t.name, t.exp[33] ? 1 : 0,
               t.exp[33] ? t.exp[16:1] : t.exp[32:17]);
    end
  endtask

  task automatic apply(input vec_t t);
    drive(t);
    #1;
    compare(t);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

  initial begin
    Reset = 1'b1;
    {M0Read, M0Write, M1Read, M1Write} = 4'b0000;
    BusDone = 1'b0;
    BusRdData = Z;
    M0Addr = A0; M0WrData = D0;
    M1Addr = A1; M1WrData = D1;

    // Continuous contention from reset: M0 wins first, then strict alternation.
    tbl.push_back(v("ct0",  4'b1001, 0, Z,        2'b00, Z,  Z,  0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct1",  4'b1001, 0, Z,        2'b10, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct2",  4'b1001, 1, 16'h0A01, 2'b10, A0, D0, 0, 2'b10, 16'h0A01, Z,        0));
    tbl.push_back(v("ct3",  4'b1001, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct4",  4'b1001, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct5",  4'b1001, 0, Z,        2'b01, A1, D1, 1, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct6",  4'b1001, 1, 16'h0B02, 2'b01, A1, D1, 1, 2'b01, Z,        16'h0B02, 0));
    tbl.push_back(v("ct7",  4'b1001, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct8",  4'b1001, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct9",  4'b1001, 0, Z,        2'b10, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct10", 4'b1001, 1, 16'h0A03, 2'b10, A0, D0, 0, 2'b10, 16'h0A03, Z,        0));
    tbl.push_back(v("ct11", 4'b1001, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct12", 4'b1001, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct13", 4'b1001, 0, Z,        2'b01, A1, D1, 1, 2'b00, Z,        Z,        0));
    tbl.push_back(v("ct14", 4'b1001, 1, 16'h0B04, 2'b01, A1, D1, 1, 2'b01, Z,        16'h0B04, 0));
    tbl.push_back(v("ct15", 4'b0000, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z,        Z,        0));
    tbl.push_back(v("idle_busdone", 4'b0000, 1, 16'hFFFF, 2'b00, A1, D1, 1, 2'b00, Z, Z,       0));
    // Single M0 read, bus completes three cycles after the request.
    tbl.push_back(v("sr0",  4'b1000, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z,        Z,        0));
    tbl.push_back(v("sr1",  4'b1000, 0, Z,        2'b10, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("sr2",  4'b1000, 0, Z,        2'b10, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("sr3",  4'b1000, 1, 16'h1234, 2'b10, A0, D0, 0, 2'b10, 16'h1234, Z,        0));
    tbl.push_back(v("sr4",  4'b0000, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("sr5",  4'b0000, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    // Read and Write together is a write.
    tbl.push_back(v("rw0",  4'b1100, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("rw1",  4'b1100, 1, 16'h7777, 2'b01, A0, D0, 0, 2'b10, 16'h7777, Z,        0));
    tbl.push_back(v("rw2",  4'b0000, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    tbl.push_back(v("rw3",  4'b0000, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    // M1 write that never completes: abort on the 8th BUSY cycle.
    tbl.push_back(v("to0",  4'b0001, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        0));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(v($sformatf("to%0d", i), 4'b0001, 0, Z, 2'b01, A1, D1, 1, 2'b00, Z, Z, 0));
    tbl.push_back(v("to8",  4'b0001, 0, Z,        2'b01, A1, D1, 1, 2'b01, Z,        16'hDEAD, 0));
    tbl.push_back(v("to9",  4'b0000, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z,        Z,        1));
    tbl.push_back(v("to10", 4'b1000, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z,        Z,        1));
    tbl.push_back(v("to11", 4'b1000, 1, 16'h4321, 2'b10, A0, D0, 0, 2'b10, 16'h4321, Z,        1));
    tbl.push_back(v("to12", 4'b0000, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        1));
    tbl.push_back(v("to13", 4'b0000, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z,        1));

    repeat (2) @(negedge Clock);
    #1;
    compare(v("reset_state", 4'b0000, 0, Z, 2'b00, Z, Z, 0, 2'b00, Z, Z, 0));
    Reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted asynchronously while a write is on the bus.
    apply(v("rs0", 4'b0100, 0, Z, 2'b00, A0, D0, 0, 2'b00, Z, Z, 1));
    apply(v("rs1", 4'b0100, 0, Z, 2'b01, A0, D0, 0, 2'b00, Z, Z, 1));
    #2;
    Reset = 1'b1;
    BusDone = 1'b1;
    #1;
    compare(v("rs_async", 4'b0100, 1, Z, 2'b00, Z, Z, 0, 2'b00, Z, Z, 0));
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    apply(v("rs2", 4'b1010, 0, Z,        2'b00, Z,  Z,  0, 2'b00, Z,        Z, 0));
    apply(v("rs3", 4'b1010, 0, Z,        2'b10, A0, D0, 0, 2'b00, Z,        Z, 0));
    apply(v("rs4", 4'b1010, 1, 16'h1111, 2'b10, A0, D0, 0, 2'b10, 16'h1111, Z, 0));
    apply(v("rs5", 4'b0010, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z, 0));
    apply(v("rs6", 4'b0010, 0, Z,        2'b00, A0, D0, 0, 2'b00, Z,        Z, 0));

    // BusDone lands on the very cycle the watchdog would abort.
    for (int i = 1; i <= 7; i++)
      apply(v($sformatf("tie%0d", i), 4'b0010, 0, Z, 2'b10, A1, D1, 1, 2'b00, Z, Z, 0));
    apply(v("tie8",  4'b0010, 1, 16'h5A5A, 2'b10, A1, D1, 1, 2'b01, Z, 16'h5A5A, 0));
    apply(v("tie9",  4'b0000, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z, Z,        0));
    apply(v("tie10", 4'b0000, 0, Z,        2'b00, A1, D1, 1, 2'b00, Z, Z,        0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
